// File: rtl/rv32_pkg.sv
// Shared RV32 memory-stage definitions: funct3 access encodings, FSM states and size decode.
package rv32_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  // Unlisted encodings (011/110/111) fall through to a full-word access
  function automatic size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory req/ack bus between the memory stage (master) and the memory (slave).
interface mem_access_if
  import rv32_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        wmask;
  logic [XLEN-1:0]   wdata;
  logic              ack;
  logic [XLEN-1:0]   rdata;

  modport master (output req, we, addr, wmask, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wmask, wdata, output ack, rdata);
endinterface

// File: rtl/mem_align.sv
// Combinational store lane/mask generator and load byte/half extractor with sign/zero extension.
module mem_align
  import rv32_pkg::*;
(
  input  logic [2:0]      st_funct3,
  input  logic [1:0]      st_off,
  input  logic [XLEN-1:0] st_data,
  output logic [3:0]      st_wmask,
  output logic [XLEN-1:0] st_wdata,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_off,
  input  logic [XLEN-1:0] ld_word,
  output logic [XLEN-1:0] ld_data
);
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_signed;

  // Store data is replicated across lanes so the mask alone picks the bytes
  always_comb begin
    st_wmask = 4'b1111;
    st_wdata = st_data;
    case (f3_size(st_funct3))
      SZ_B: begin
        st_wmask = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      SZ_H: begin
        st_wmask = 4'b0011 << {st_off[1], 1'b0};
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte   = ld_word[{ld_off, 3'b000} +: 8];
    ld_half   = ld_word[{ld_off[1], 4'b0000} +: 16];
    ld_signed = ~ld_funct3[2];
    ld_data   = ld_word;
    case (f3_size(ld_funct3))
      SZ_B:    ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      SZ_H:    ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// RV32I memory stage: issues req/ack data-memory transactions and formats writeback data.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of issuing them.
module mem_access
  import rv32_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
)(
  input  logic            clk,
  input  logic            clr_n,
  input  logic            in_valid,
  input  logic            is_load,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] alu,
  input  logic [XLEN-1:0] rd2,
  input  logic [4:0]      rad,
  output logic            stall,
  mem_access_if.master    dmem,
  output logic            out_valid,
  output logic [4:0]      out_rad,
  output logic [XLEN-1:0] out_rdd,
  output logic            out_trap
);
  state_e          state_q, state_d;
  logic            is_mem, misalign, accept, start, done;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [4:0]      rad_q;
  logic [3:0]      st_wmask;
  logic [XLEN-1:0] st_wdata, ld_data;

  assign is_mem = is_load | is_store;

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    if (is_mem) begin
      case (f3_size(funct3))
        SZ_H:    misalign = alu[0];
        SZ_W:    misalign = |alu[1:0];
        default: misalign = 1'b0;
      endcase
    end
  end
`else
  assign misalign = 1'b0;
`endif

  mem_align u_align (
    .st_funct3 (funct3),
    .st_off    (alu[1:0]),
    .st_data   (rd2),
    .st_wmask  (st_wmask),
    .st_wdata  (st_wdata),
    .ld_funct3 (f3_q),
    .ld_off    (off_q),
    .ld_word   (dmem.rdata),
    .ld_data   (ld_data)
  );

  // Next state plus the combinational stall seen by the upstream stage
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    start   = 1'b0;
    done    = 1'b0;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept = 1'b1;
          if (is_mem && !misalign) begin
            start   = 1'b1;
            stall   = 1'b1;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (dmem.ack) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Bus request fields stay frozen from issue until ack
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      dmem.req   <= 1'b0;
      dmem.we    <= 1'b0;
      dmem.addr  <= '0;
      dmem.wmask <= '0;
      dmem.wdata <= '0;
      f3_q       <= '0;
      off_q      <= '0;
      rad_q      <= '0;
      out_valid  <= 1'b0;
      out_rad    <= '0;
      out_rdd    <= '0;
      out_trap   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_trap  <= 1'b0;
      if (start) begin
        dmem.req   <= 1'b1;
        dmem.we    <= is_store;
        dmem.addr  <= {alu[ADDR_W-1:2], 2'b00};
        dmem.wmask <= is_store ? st_wmask : 4'b0000;
        dmem.wdata <= st_wdata;
        f3_q       <= funct3;
        off_q      <= alu[1:0];
        rad_q      <= rad;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_rdd   <= alu;
        out_rad   <= misalign ? 5'd0 : rad;
        out_trap  <= misalign;
      end
      if (done) begin
        dmem.req  <= 1'b0;
        out_valid <= 1'b1;
        out_rdd   <= dmem.we ? '0 : ld_data;
        out_rad   <= dmem.we ? 5'd0 : rad_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: randomized traffic checked every cycle against a transaction-level model,
// plus directed cases with hand-computed results. Honours MEM_MISALIGN_TRAP_EN when defined.
module tb_mem_access;
  import rv32_pkg::*;

  localparam int unsigned ADDR_W = 32;

  typedef struct packed {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [4:0]  rad;
  } instr_t;

  logic        clk      = 1'b0;
  logic        clr_n    = 1'b0;
  logic        in_valid = 1'b0;
  logic        is_load  = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3   = '0;
  logic [31:0] alu      = '0;
  logic [31:0] rd2      = '0;
  logic [4:0]  rad      = '0;
  logic        stall, out_valid, out_trap;
  logic [4:0]  out_rad;
  logic [31:0] out_rdd;

  mem_access_if #(.ADDR_W(ADDR_W)) dmem ();

  mem_access #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .in_valid  (in_valid),
    .is_load   (is_load),
    .is_store  (is_store),
    .funct3    (funct3),
    .alu       (alu),
    .rd2       (rd2),
    .rad       (rad),
    .stall     (stall),
    .dmem      (dmem),
    .out_valid (out_valid),
    .out_rad   (out_rad),
    .out_rdd   (out_rdd),
    .out_trap  (out_trap)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference rules ----------------
  function automatic int sz(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ld_ext(input logic [2:0] f3, input int off, input logic [31:0] w);
    int n;
    logic [31:0] v;
    n = sz(f3);
    if (n == 4) return w;
    v = w >> (8 * (off - (off % n)));
    v = v & ((32'd1 << (8 * n)) - 32'd1);
    if (f3[2] == 1'b0 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  function automatic logic [3:0] wmask_of(input logic [2:0] f3, input int off);
    if (sz(f3) == 1) return 4'(1 << off);
    if (sz(f3) == 2) return 4'(3 << (off - (off % 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] wdata_of(input logic [2:0] f3, input logic [31:0] d);
    if (sz(f3) == 1) return 32'(d[7:0]) * 32'h0101_0101;
    if (sz(f3) == 2) return 32'(d[15:0]) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    return (sz(f3) == 2 && a[0]) || (sz(f3) == 4 && a[1:0] != 2'b00);
`else
    return 1'b0 && (a[0] | f3[0]);
`endif
  endfunction

  function automatic instr_t mk(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
    instr_t x;
    x.ld = ld; x.st = st; x.f3 = f3; x.alu = a; x.rd2 = d; x.rad = r;
    return x;
  endfunction

  function automatic instr_t rand_instr();
    int k;
    k = int'($urandom_range(0, 9));
    return mk((k < 4) || (k == 9), (k >= 4 && k < 7) || (k == 9), 3'($urandom_range(0, 7)),
              $urandom, $urandom, 5'($urandom_range(0, 31)));
  endfunction

  // ---------------- transaction-level model ----------------
  logic        m_busy, m_req, m_we, m_ov, m_trap, accepted;
  logic [31:0] m_addr, m_wdata, m_rdd;
  logic [3:0]  m_wmask;
  logic [4:0]  m_rad, p_rad;
  logic [2:0]  p_f3;
  int          p_off;

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_busy <= 1'b0; m_req <= 1'b0; m_ov <= 1'b0; m_trap <= 1'b0; accepted <= 1'b0;
    end else begin
      accepted <= 1'b0;
      m_ov     <= 1'b0;
      m_trap   <= 1'b0;
      if (m_busy) begin
        if (dmem.ack === 1'b1) begin
          m_busy <= 1'b0;
          m_req  <= 1'b0;
          m_ov   <= 1'b1;
          m_rdd  <= m_we ? 32'd0 : ld_ext(p_f3, p_off, dmem.rdata);
          m_rad  <= m_we ? 5'd0 : p_rad;
        end
      end else if (in_valid) begin
        accepted <= 1'b1;
        if ((is_load || is_store) && !mis(funct3, alu)) begin
          m_busy  <= 1'b1;
          m_req   <= 1'b1;
          m_we    <= is_store;
          m_addr  <= alu & 32'hFFFF_FFFC;
          m_wmask <= is_store ? wmask_of(funct3, int'(alu[1:0])) : 4'h0;
          m_wdata <= wdata_of(funct3, rd2);
          p_f3    <= funct3;
          p_off   <= int'(alu[1:0]);
          p_rad   <= rad;
        end else begin
          m_ov   <= 1'b1;
          m_rdd  <= alu;
          m_trap <= is_load || is_store;
          m_rad  <= (is_load || is_store) ? 5'd0 : rad;
        end
      end
    end
  end

  // ---------------- per-cycle driver / responder / compare ----------------
  instr_t      iq[$];
  int          dly_q[$];
  logic [31:0] rdq[$];
  bit          rand_en = 0, armed = 0, stray = 0;
  int          dcount  = 0;
  bit          ov_seen, drove, req_seen;
  logic [31:0] ob_rdd, ob_addr, ob_wdata;
  logic [4:0]  ob_rad;
  logic        ob_trap;
  logic [3:0]  ob_wmask;
  int          stall_cnt;

  task automatic step();
    instr_t ins;
    bit     have;
    @(negedge clk);
    ov_seen = 0;
    drove   = 0;
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("out_trap", 32'(out_trap), 32'(m_trap));
    check("dmem_req", 32'(dmem.req), 32'(m_req));
    if (m_ov) begin
      check("out_rdd", out_rdd, m_rdd);
      check("out_rad", 32'(out_rad), 32'(m_rad));
      ov_seen = 1; ob_rdd = out_rdd; ob_rad = out_rad; ob_trap = out_trap;
    end
    if (m_req) begin
      check("dmem_we", 32'(dmem.we), 32'(m_we));
      check("dmem_addr", dmem.addr, m_addr);
      check("dmem_wmask", 32'(dmem.wmask), 32'(m_wmask));
      if (m_we) check("dmem_wdata", dmem.wdata, m_wdata);
      req_seen = 1; ob_addr = dmem.addr; ob_wmask = dmem.wmask; ob_wdata = dmem.wdata;
    end
    // a presented instruction is held until the model says it was taken
    if (!(in_valid && !accepted)) begin
      have = 0;
      ins  = '0;
      if (iq.size() > 0) begin
        ins = iq.pop_front(); have = 1;
      end else if (rand_en && $urandom_range(0, 2) != 0) begin
        ins = rand_instr(); have = 1;
      end
      in_valid = have;
      is_load  = ins.ld; is_store = ins.st; funct3 = ins.f3;
      alu      = ins.alu; rd2 = ins.rd2; rad = ins.rad;
      drove    = have;
    end
    if (m_busy) begin
      if (!armed) begin
        armed = 1;
        if (dly_q.size() > 0) dcount = dly_q.pop_front();
        else dcount = int'($urandom_range(0, 3));
      end
      if (dcount == 0) begin
        dmem.ack = 1'b1;
        if (rdq.size() > 0) dmem.rdata = rdq.pop_front();
        else dmem.rdata = $urandom;
        armed = 0;
      end else begin
        dmem.ack = 1'b0;
        dcount--;
      end
    end else begin
      armed      = 0;
      dmem.ack   = stray || (rand_en && $urandom_range(0, 7) == 0);
      dmem.rdata = $urandom;
    end
    #1;
    check("stall", 32'(stall),
          32'(m_busy || (in_valid && (is_load || is_store) && !mis(funct3, alu))));
    if (stall) stall_cnt++;
  endtask

  // one directed instruction; lat = cycles from presentation to out_valid
  task automatic run1(input instr_t ins, input int dly, input logic [31:0] rdw, output int lat);
    bit started;
    int n;
    started = 0; n = 0; lat = -1; req_seen = 0; stall_cnt = 0;
    dly_q.delete(); rdq.delete();
    iq.push_back(ins); dly_q.push_back(dly); rdq.push_back(rdw);
    for (int i = 0; i < 40 && lat < 0; i++) begin
      step();
      if (started) begin
        n++;
        if (ov_seen) lat = n;
      end
      if (drove) started = 1;
    end
    check("result_in_time", 32'(lat >= 0), 32'd1);
  endtask

  initial begin
    int lat, ov1, ov2, idx;
    bit any_act;
    dmem.ack   = 1'b0;
    dmem.rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_req", 32'(dmem.req), 32'd0);
    check("rst_we", 32'(dmem.we), 32'd0);
    check("rst_addr", dmem.addr, 32'd0);
    check("rst_wmask", 32'(dmem.wmask), 32'd0);
    check("rst_wdata", dmem.wdata, 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_rad", 32'(out_rad), 32'd0);
    check("rst_out_rdd", out_rdd, 32'd0);
    check("rst_out_trap", 32'(out_trap), 32'd0);
    clr_n = 1'b1;

    run1(mk(0, 0, F3_W, 32'h1234, 32'h0, 5'd5), 0, 32'h0, lat);
    check("alu_lat", 32'(lat), 32'd1);
    check("alu_rdd", ob_rdd, 32'h1234);
    check("alu_rad", 32'(ob_rad), 32'd5);
    check("alu_no_req", 32'(req_seen), 32'd0);

    run1(mk(0, 1, F3_B, 32'h103, 32'hAB, 5'd7), 3, 32'h0, lat);
    check("sb_addr", ob_addr, 32'h100);
    check("sb_wmask", 32'(ob_wmask), 32'h8);
    check("sb_wdata", ob_wdata, 32'hABAB_ABAB);
    check("sb_lat", 32'(lat), 32'd5);
    check("sb_stall_cycles", 32'(stall_cnt), 32'd5);
    check("sb_rad", 32'(ob_rad), 32'd0);
    check("sb_rdd", ob_rdd, 32'd0);

    run1(mk(1, 0, F3_B, 32'h102, 32'h0, 5'd9), 1, 32'h0080_0000, lat);
    check("lb_rdd", ob_rdd, 32'hFFFF_FF80);
    check("lb_rad", 32'(ob_rad), 32'd9);
    check("lb_wmask", 32'(ob_wmask), 32'd0);
    run1(mk(1, 0, F3_BU, 32'h102, 32'h0, 5'd9), 2, 32'h0080_0000, lat);
    check("lbu_rdd", ob_rdd, 32'h0000_0080);
    run1(mk(1, 0, F3_HU, 32'h102, 32'h0, 5'd3), 0, 32'hBEEF_0000, lat);
    check("lhu_rdd", ob_rdd, 32'h0000_BEEF);
    run1(mk(1, 0, F3_H, 32'h102, 32'h0, 5'd3), 0, 32'hBEEF_0000, lat);
    check("lh_rdd", ob_rdd, 32'hFFFF_BEEF);
    run1(mk(0, 1, F3_H, 32'h206, 32'h1234_5678, 5'd3), 0, 32'h0, lat);
    check("sh_wmask", 32'(ob_wmask), 32'hC);
    check("sh_wdata", ob_wdata, 32'h5678_5678);

    run1(mk(1, 0, F3_W, 32'h200, 32'h0, 5'd1), 0, 32'hDEAD_BEEF, lat);
    check("lw_lat", 32'(lat), 32'd2);
    check("lw_rdd", ob_rdd, 32'hDEAD_BEEF);

    // back-to-back words: the second is held until the first completes
    dly_q.delete(); rdq.delete();
    iq.push_back(mk(1, 0, F3_W, 32'h400, 32'h0, 5'd2)); dly_q.push_back(0); rdq.push_back(32'h1111_1111);
    iq.push_back(mk(1, 0, F3_W, 32'h404, 32'h0, 5'd3)); dly_q.push_back(0); rdq.push_back(32'h2222_2222);
    ov1 = -1; ov2 = -1;
    for (idx = 0; idx < 20; idx++) begin
      step();
      if (ov_seen && ov1 < 0) ov1 = idx;
      else if (ov_seen && ov2 < 0) ov2 = idx;
    end
    check("b2b_gap", 32'(ov2 - ov1), 32'd2);
    check("b2b_rdd", ob_rdd, 32'h2222_2222);

    run1(mk(1, 0, F3_W, 32'h102, 32'h0, 5'd6), 0, 32'hCAFE_F00D, lat);
`ifdef MEM_MISALIGN_TRAP_EN
    check("mis_no_req", 32'(req_seen), 32'd0);
    check("mis_trap", 32'(ob_trap), 32'd1);
    check("mis_rdd", ob_rdd, 32'h102);
    check("mis_rad", 32'(ob_rad), 32'd0);
    check("mis_lat", 32'(lat), 32'd1);
`else
    check("mis_addr", ob_addr, 32'h100);
    check("mis_trap", 32'(ob_trap), 32'd0);
    check("mis_rdd", ob_rdd, 32'hCAFE_F00D);
    check("mis_lat", 32'(lat), 32'd2);
`endif

    dly_q.delete(); rdq.delete();
    rand_en = 1;
    repeat (3000) step();
    rand_en = 0;
    repeat (10) step();

    // abort an open transaction with reset, then offer stray acks
    dly_q.delete(); rdq.delete();
    req_seen = 0;
    iq.push_back(mk(1, 0, F3_W, 32'h300, 32'h0, 5'd4)); dly_q.push_back(10);
    for (int i = 0; i < 10 && !req_seen; i++) step();
    check("abort_req_open", 32'(req_seen), 32'd1);
    #2 clr_n = 1'b0;
    #1;
    check("abort_req", 32'(dmem.req), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_stall", 32'(stall), 32'd0);
    check("abort_addr", dmem.addr, 32'd0);
    check("abort_out_rdd", out_rdd, 32'd0);
    stray   = 1;
    any_act = 0;
    repeat (2) step();
    #2 clr_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid !== 1'b0 || dmem.req !== 1'b0) any_act = 1;
    end
    check("stray_ack_ignored", 32'(any_act), 32'd0);
    stray = 0;
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
